program_counter_ras: RTL and testbench
======================================

// Module: program_counter_ras
// PURPOSE
//  Next-generation program counter for the TP3 datapath. Parametrised address width.
//  Adds sequential increment, absolute load (WrPC), call/return through an internal
//  return-address stack (RAS), and a halt/resume state.
//  Sits between the control unit (command strobes) and program memory (Addr).
// PARAMETERS
//  ADDR_W      11  width of Addr, address_bus and each RAS entry
//  RAS_DEPTH   4   return-address stack entries (power of 2, >=2)
//  RESET_ADDR  0   value loaded into Addr on reset
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous, active-low reset
//  en             in   1       advance: Addr <= Addr+1
//  WrPC           in   1       absolute load: Addr <= address_bus
//  call           in   1       push Addr+1, then Addr <= address_bus
//  ret            in   1       pop: Addr <= top of RAS
//  halt           in   1       enter HALT; Addr frozen
//  resume         in   1       leave HALT
//  address_bus    in   ADDR_W  jump/call target
//  Addr           out  ADDR_W  current program address (registered)
//  halted         out  1       1 while in HALT
//  ras_full       out  1       RAS holds RAS_DEPTH entries
//  ras_empty      out  1       RAS holds 0 entries
//  ovf_err        out  1       sticky: call attempted while full
//  unf_err        out  1       sticky: ret attempted while empty
// BEHAVIOUR
//  - Reset (async assert, sync-released by the system): Addr=RESET_ADDR, state=RUN,
//    RAS pointer=0, ras_empty=1, ras_full=0, halted=0, ovf_err=unf_err=0.
//  - All outputs registered or decoded from registers; 1-cycle latency from strobe to Addr.
//  - FSM: RUN, HALT. RUN --halt--> HALT; HALT --resume & !halt--> RUN.
//    In HALT every other command is ignored; Addr and RAS hold.
//  - Command priority in RUN, one action per cycle: halt > ret > call > WrPC > en.
//    If no command is asserted, Addr holds.
//  - en: Addr <= Addr+1 modulo 2^ADDR_W (max value wraps to 0, no flag).
//  - call, not full: RAS[ptr] <= Addr+1 (wrapped); ptr++; Addr <= address_bus.
//  - call while full: no push, Addr holds, ovf_err <= 1.
//  - ret, not empty: Addr <= RAS[ptr-1]; ptr--.
//  - ret while empty: Addr holds, unf_err <= 1.
//  - call & ret in the same cycle: ret executes, call is dropped (no error).
//  - Error flags are sticky; only rst_n clears them.
//  - ptr is ADDR-independent, range 0..RAS_DEPTH.
//    ras_full = (ptr==RAS_DEPTH); ras_empty = (ptr==0).
//  - Reset mid-operation (any state) returns immediately to the reset values.
//    RAS contents need not clear; they are unreachable while ptr=0.
// STRUCTURE
//  - pc_pkg: state enum {PC_RUN, PC_HALT}; localparam PTR_W = $clog2(RAS_DEPTH)+1.
//  - Sub-module ras_stack (ADDR_W, RAS_DEPTH): push/pop/data_in/top/full/empty.
//    Contains pointer and storage; async active-low reset on the pointer only.
//  - Top: FSM, priority decode, Addr register, sticky error flags.
// TESTING
//  1. Reset, then en for 3 cycles -> Addr 0,1,2,3; ras_empty=1; halted=0.
//  2. ADDR_W=11, WrPC address_bus=11'h7FF, then en -> Addr=7FF, then 000.
//  3. Addr=5: call to 0x40; at 0x41 call to 0x80; ret; ret
//     -> Addr 0x40, 0x80, 0x42, 6; ras_empty=1 at end.
//  4. Five calls with RAS_DEPTH=4 -> ras_full after 4th; 5th: Addr holds, ovf_err=1.
//     ret on empty RAS -> unf_err=1, Addr holds.
//  5. halt, then en/WrPC/call for 4 cycles -> Addr frozen, halted=1;
//     resume -> halted=0, next en increments.
//  6. call & ret same cycle with 1 entry (0x10) -> Addr=0x10, ras_empty=1, ovf_err=0.
//     Assert rst_n=0 mid-sequence -> outputs reset without waiting for clk.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter with return-address stack.
package pc_pkg;

  typedef enum logic {
    PC_RUN  = 1'b0,
    PC_HALT = 1'b1
  } pc_state_e;

  // Pointer width covering 0..depth inclusive.
  function automatic int ras_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: pointer plus storage. Only the pointer is reset;
// stale entries cannot be read while the pointer is zero.
module ras_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] data_in,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = ras_ptr_w(RAS_DEPTH);
  localparam int IDX_W = $clog2(RAS_DEPTH);

  logic [PTR_W-1:0]  ptr;
  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [IDX_W-1:0]  top_idx;
  logic              do_push;
  logic              do_pop;

  assign full    = (ptr == PTR_W'(RAS_DEPTH));
  assign empty   = (ptr == '0);
  assign top_idx = ptr[IDX_W-1:0] - IDX_W'(1);
  assign top     = mem[top_idx];

  // Pop wins if both are requested; the top level never asks for both.
  assign do_pop  = pop && !empty;
  assign do_push = push && !full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (do_pop) begin
      ptr <= ptr - PTR_W'(1);
    end else if (do_push) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[ptr[IDX_W-1:0]] <= data_in;
    end
  end

endmodule

// File: rtl/program_counter_ras.sv
// Program counter with increment, absolute load, call/return via a
// return-address stack, and a RUN/HALT state machine.
module program_counter_ras
  import pc_pkg::*;
#(
  parameter int               ADDR_W     = 11,
  parameter int               RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              WrPC,
  input  logic              call,
  input  logic              ret,
  input  logic              halt,
  input  logic              resume,
  input  logic [ADDR_W-1:0] address_bus,
  output logic [ADDR_W-1:0] Addr,
  output logic              halted,
  output logic              ras_full,
  output logic              ras_empty,
  output logic              ovf_err,
  output logic              unf_err,
  output pc_state_e         state_dbg
);

  pc_state_e         state;
  pc_state_e         state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_push;
  logic              ras_pop;
  logic              set_ovf;
  logic              set_unf;

  assign addr_inc = Addr + ADDR_W'(1);

  ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (ras_push),
    .pop    (ras_pop),
    .data_in(addr_inc),
    .top    (ras_top),
    .full   (ras_full),
    .empty  (ras_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PC_RUN;
      Addr    <= RESET_ADDR;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      Addr    <= addr_nxt;
      ovf_err <= ovf_err | set_ovf;
      unf_err <= unf_err | set_unf;
    end
  end

  // One action per cycle in RUN: halt > ret > call > WrPC > en.
  always_comb begin
    state_nxt = state;
    addr_nxt  = Addr;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    unique case (state)
      PC_RUN: begin
        if (halt) begin
          state_nxt = PC_HALT;
        end else if (ret) begin
          if (!ras_empty) begin
            ras_pop  = 1'b1;
            addr_nxt = ras_top;
          end else begin
            set_unf = 1'b1;
          end
        end else if (call) begin
          if (!ras_full) begin
            ras_push = 1'b1;
            addr_nxt = address_bus;
          end else begin
            set_ovf = 1'b1;
          end
        end else if (WrPC) begin
          addr_nxt = address_bus;
        end else if (en) begin
          addr_nxt = addr_inc;
        end
      end
      PC_HALT: begin
        if (resume && !halt) begin
          state_nxt = PC_RUN;
        end
      end
      default: state_nxt = PC_RUN;
    endcase
  end

  assign halted    = (state == PC_HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_program_counter_ras.sv
// Bench for program_counter_ras: directed scenarios plus randomized commands
// checked against a queue-based reference model.
module tb_program_counter_ras;
  import pc_pkg::*;

  localparam int         AW    = 11;
  localparam int         DEPTH = 4;
  localparam logic [10:0] RST_A = 11'h000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, wrpc = 1'b0, call = 1'b0, ret = 1'b0;
  logic          halt = 1'b0, resume = 1'b0;
  logic [AW-1:0] address_bus = '0;
  logic [AW-1:0] addr;
  logic          halted, ras_full, ras_empty, ovf_err, unf_err;
  pc_state_e     state_dbg;

  int checks = 0;
  int failures = 0;

  // Reference model
  logic [AW-1:0] m_addr;
  logic [AW-1:0] m_ras[$];
  logic          m_halt, m_ovf, m_unf;

  always #5 clk = ~clk;

  program_counter_ras #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_ADDR(RST_A)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrPC(wrpc), .call(call), .ret(ret),
    .halt(halt), .resume(resume), .address_bus(address_bus), .Addr(addr),
    .halted(halted), .ras_full(ras_full), .ras_empty(ras_empty),
    .ovf_err(ovf_err), .unf_err(unf_err), .state_dbg(state_dbg)
  );

  function automatic logic [4:0] dut_flags();
    return {halted, ras_full, ras_empty, ovf_err, unf_err};
  endfunction

  function automatic logic [4:0] exp_flags();
    return {m_halt, (m_ras.size() == DEPTH), (m_ras.size() == 0), m_ovf, m_unf};
  endfunction

  function automatic void model_reset();
    m_addr = RST_A;
    m_ras.delete();
    m_halt = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endfunction

  function automatic void model_step(input logic e, w, c, r, h, rs, input logic [AW-1:0] b);
    if (m_halt) begin
      if (rs && !h) m_halt = 1'b0;
    end else if (h) begin
      m_halt = 1'b1;
    end else if (r) begin
      if (m_ras.size() > 0) m_addr = m_ras.pop_back();
      else m_unf = 1'b1;
    end else if (c) begin
      if (m_ras.size() < DEPTH) begin
        m_ras.push_back(m_addr + 11'd1);
        m_addr = b;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (w) begin
      m_addr = b;
    end else if (e) begin
      m_addr = m_addr + 11'd1;
    end
  endfunction

  // Drive one cycle of commands; returns at posedge+1 with the model updated.
  task automatic step(input logic e, w, c, r, h, rs, input logic [AW-1:0] b);
    en = e; wrpc = w; call = c; ret = r; halt = h; resume = rs; address_bus = b;
    @(posedge clk);
    model_step(e, w, c, r, h, rs, b);
    #1;
  endtask

  // Assert reset away from any clock edge; leaves rst_n low for the caller to check.
  task automatic assert_reset();
    en = 0; wrpc = 0; call = 0; ret = 0; halt = 0; resume = 0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    assert_reset();
    checks++;
    if (addr !== RST_A) begin
      failures++; $display("FAIL reset_addr got=%h exp=%h", addr, RST_A);
    end
    checks++;
    if (dut_flags() !== 5'b00100) begin
      failures++; $display("FAIL reset_flags got=%b exp=%b", dut_flags(), 5'b00100);
    end
    release_reset();
  endtask

  task automatic test_increment();
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0, 0, 0, '0);
      checks++;
      if (addr !== 11'(i)) begin
        failures++; $display("FAIL inc_addr got=%h exp=%h", addr, 11'(i));
      end
    end
    checks++;
    if (dut_flags() !== 5'b00100) begin
      failures++; $display("FAIL inc_flags got=%b exp=%b", dut_flags(), 5'b00100);
    end
  endtask

  task automatic test_wrap();
    step(0, 1, 0, 0, 0, 0, 11'h7FF);
    checks++;
    if (addr !== 11'h7FF) begin
      failures++; $display("FAIL wrpc_max got=%h exp=%h", addr, 11'h7FF);
    end
    step(1, 0, 0, 0, 0, 0, '0);
    checks++;
    if (addr !== 11'h000) begin
      failures++; $display("FAIL wrap_zero got=%h exp=%h", addr, 11'h000);
    end
  endtask

  task automatic test_call_ret();
    logic [AW-1:0] exp_a[4];
    exp_a[0] = 11'h040; exp_a[1] = 11'h080; exp_a[2] = 11'h042; exp_a[3] = 11'h006;
    assert_reset();
    release_reset();
    step(0, 1, 0, 0, 0, 0, 11'h005);
    step(0, 0, 1, 0, 0, 0, 11'h040);
    checks++;
    if (addr !== exp_a[0]) begin
      failures++; $display("FAIL call1 got=%h exp=%h", addr, exp_a[0]);
    end
    step(1, 0, 0, 0, 0, 0, '0);
    step(0, 0, 1, 0, 0, 0, 11'h080);
    checks++;
    if (addr !== exp_a[1]) begin
      failures++; $display("FAIL call2 got=%h exp=%h", addr, exp_a[1]);
    end
    step(0, 0, 0, 1, 0, 0, '0);
    checks++;
    if (addr !== exp_a[2]) begin
      failures++; $display("FAIL ret1 got=%h exp=%h", addr, exp_a[2]);
    end
    step(0, 0, 0, 1, 0, 0, '0);
    checks++;
    if (addr !== exp_a[3] || ras_empty !== 1'b1) begin
      failures++; $display("FAIL ret2 got=%h empty=%b exp=%h empty=1", addr, ras_empty, exp_a[3]);
    end
  endtask

  task automatic test_overflow_underflow();
    logic [AW-1:0] held;
    assert_reset();
    release_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 11'($urandom_range(0, 2047)));
    checks++;
    if (ras_full !== 1'b1 || ovf_err !== 1'b0) begin
      failures++; $display("FAIL full_after4 got full=%b ovf=%b exp full=1 ovf=0", ras_full, ovf_err);
    end
    held = m_addr;
    step(0, 0, 1, 0, 0, 0, 11'h123);
    checks++;
    if (addr !== held || ovf_err !== 1'b1) begin
      failures++; $display("FAIL call_full got=%h ovf=%b exp=%h ovf=1", addr, ovf_err, held);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0, 0, '0);
      checks++;
      if (addr !== m_addr) begin
        failures++; $display("FAIL pop_seq got=%h exp=%h", addr, m_addr);
      end
    end
    held = m_addr;
    step(0, 0, 0, 1, 0, 0, '0);
    checks++;
    if (addr !== held || dut_flags() !== 5'b00111) begin
      failures++; $display("FAIL ret_empty got=%h flags=%b exp=%h flags=%b", addr, dut_flags(), held, 5'b00111);
    end
  endtask

  task automatic test_halt();
    logic [AW-1:0] held;
    assert_reset();
    release_reset();
    step(0, 1, 0, 0, 0, 0, 11'h234);
    step(0, 0, 0, 0, 1, 0, '0);
    held = 11'h234;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 0, 0, 0, 11'($urandom_range(0, 2047)));
      checks++;
      if (addr !== held || halted !== 1'b1 || ras_empty !== 1'b1) begin
        failures++; $display("FAIL halt_frozen got=%h halted=%b exp=%h halted=1", addr, halted, held);
      end
    end
    step(0, 0, 0, 0, 0, 1, '0);
    checks++;
    if (halted !== 1'b0 || addr !== held) begin
      failures++; $display("FAIL resume got halted=%b addr=%h exp halted=0 addr=%h", halted, addr, held);
    end
    step(1, 0, 0, 0, 0, 0, '0);
    checks++;
    if (addr !== 11'h235) begin
      failures++; $display("FAIL resume_inc got=%h exp=%h", addr, 11'h235);
    end
  endtask

  task automatic test_call_ret_same();
    assert_reset();
    release_reset();
    step(0, 1, 0, 0, 0, 0, 11'h00F);
    step(0, 0, 1, 0, 0, 0, 11'h300);
    step(0, 0, 1, 1, 0, 0, 11'h500);
    checks++;
    if (addr !== 11'h010 || dut_flags() !== 5'b00100) begin
      failures++; $display("FAIL call_ret_same got=%h flags=%b exp=%h flags=%b", addr, dut_flags(), 11'h010, 5'b00100);
    end
    step(0, 0, 1, 0, 0, 0, 11'h3AA);
    assert_reset();
    checks++;
    if (addr !== RST_A || dut_flags() !== 5'b00100) begin
      failures++; $display("FAIL async_reset got=%h flags=%b exp=%h flags=%b", addr, dut_flags(), RST_A, 5'b00100);
    end
    release_reset();
  endtask

  task automatic test_random();
    logic e, w, c, r, h, rs;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        assert_reset();
        checks++;
        if (addr !== RST_A || dut_flags() !== 5'b00100) begin
          failures++; $display("FAIL rand_reset got=%h flags=%b", addr, dut_flags());
        end
        release_reset();
      end
      e  = ($urandom_range(0, 99) < 60);
      w  = ($urandom_range(0, 99) < 10);
      c  = ($urandom_range(0, 99) < 25);
      r  = ($urandom_range(0, 99) < 20);
      h  = ($urandom_range(0, 99) < 4);
      rs = ($urandom_range(0, 99) < 30);
      step(e, w, c, r, h, rs, 11'($urandom_range(0, 2047)));
      checks++;
      if (addr !== m_addr || dut_flags() !== exp_flags()) begin
        failures++;
        $display("FAIL random cyc=%0d got addr=%h flags=%b exp addr=%h flags=%b",
                 n, addr, dut_flags(), m_addr, exp_flags());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_increment();
    test_wrap();
    test_call_ret();
    test_overflow_underflow();
    test_halt();
    test_call_ret_same();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
